// File: rtl/stopwatch_pkg.sv
// Shared digit widths, digit limits, count-mode enum and the packed time record
// used by the stopwatch controller and its digit cells.
package stopwatch_pkg;

   localparam int MIN_W  = 4;
   localparam int SEC1_W = 3;
   localparam int SEC0_W = 4;
   localparam int DECI_W = 4;

   localparam int DECI_MAX = 9;
   localparam int SEC0_MAX = 9;
   localparam int SEC1_MAX = 5;

   typedef enum logic {
      MODE_UP   = 1'b0,
      MODE_DOWN = 1'b1
   } mode_e;

   typedef struct packed {
      logic [MIN_W-1:0]  min;
      logic [SEC1_W-1:0] sec1;
      logic [SEC0_W-1:0] sec0;
      logic [DECI_W-1:0] deci;
   } time_t;

   function automatic logic is_zero(time_t t);
      return t == '0;
   endfunction

endpackage

// File: rtl/bcd_digit_updown.sv
// One registered decimal digit counting 0..MAX up or down; load beats enable.
// co_o flags the carry (up, at MAX) or borrow (down, at 0) of an enabled step.
module bcd_digit_updown
   import stopwatch_pkg::*;
#(
   parameter int W   = 4,
   parameter int MAX = 9
) (
   input  logic         clk,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   input  logic         down_i,
   output logic [W-1:0] val_o,
   output logic         co_o
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] val_q, val_d;

   always_comb begin
      val_d = val_q;
      if (load_i) begin
         val_d = load_val_i;
      end else if (en_i) begin
         if (down_i) begin
            val_d = (val_q == '0) ? MAX_V : val_q - 1'b1;
         end else begin
            val_d = (val_q == MAX_V) ? '0 : val_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr_i) begin
         val_q <= '0;
      end else begin
         val_q <= val_d;
      end
   end

   assign val_o = val_q;
   assign co_o  = en_i && (down_i ? (val_q == '0) : (val_q == MAX_V));

endmodule

// File: rtl/stopwatch_ctrl.sv
// min:sec1 sec0.deci stopwatch with start/stop, up/down count, preset load and tick prescaler.
// Optional lap-hold display is built when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = 1,
   parameter int MAX_MIN  = 9
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start_stop,
   input  logic              mode,
   input  logic              load,
   input  logic [MIN_W-1:0]  preset_min,
   input  logic [SEC1_W-1:0] preset_sec1,
   input  logic [SEC0_W-1:0] preset_sec0,
   input  logic [DECI_W-1:0] preset_deci,
   input  logic              lap,
   output logic [MIN_W-1:0]  min,
   output logic [SEC1_W-1:0] sec1,
   output logic [SEC0_W-1:0] sec0,
   output logic [DECI_W-1:0] deci,
   output logic              running,
   output logic              wrapped,
   output logic              done,
   output logic              lap_held
);

   localparam int               PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [MIN_W-1:0] MIN_MAX_V  = MIN_W'(MAX_MIN);

   typedef enum logic {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e        state_q, state_d;
   mode_e         mode_q, mode_d;
   logic          done_q, done_d;
   logic          wrapped_q, wrapped_d;
   logic [PW-1:0] presc_q, presc_d;

   time_t live, shown, preset_sat;
   logic  tick, adv, down, at_one;
   logic  deci_co, sec0_co, sec1_co, min_co;
   logic [MIN_W-1:0]  min_v;
   logic [SEC1_W-1:0] sec1_v;
   logic [SEC0_W-1:0] sec0_v;
   logic [DECI_W-1:0] deci_v;

   always_comb begin
      preset_sat.min  = (preset_min  > MIN_MAX_V)            ? MIN_MAX_V            : preset_min;
      preset_sat.sec1 = (preset_sec1 > SEC1_W'(SEC1_MAX))    ? SEC1_W'(SEC1_MAX)    : preset_sec1;
      preset_sat.sec0 = (preset_sec0 > SEC0_W'(SEC0_MAX))    ? SEC0_W'(SEC0_MAX)    : preset_sec0;
      preset_sat.deci = (preset_deci > DECI_W'(DECI_MAX))    ? DECI_W'(DECI_MAX)    : preset_deci;
   end

   // A tick coinciding with load or start_stop is dropped so stop freezes the digits.
   assign tick   = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
   assign adv    = tick && !load && !start_stop;
   assign down   = (mode_q == MODE_DOWN);
   assign live   = {min_v, sec1_v, sec0_v, deci_v};
   assign at_one = (live.min == '0) && (live.sec1 == '0) && (live.sec0 == '0)
                   && (live.deci == DECI_W'(1));

   bcd_digit_updown #(.W(DECI_W), .MAX(DECI_MAX)) u_deci (
      .clk(clk), .clr_i(clr), .load_i(load), .load_val_i(preset_sat.deci),
      .en_i(adv), .down_i(down), .val_o(deci_v), .co_o(deci_co)
   );
   bcd_digit_updown #(.W(SEC0_W), .MAX(SEC0_MAX)) u_sec0 (
      .clk(clk), .clr_i(clr), .load_i(load), .load_val_i(preset_sat.sec0),
      .en_i(deci_co), .down_i(down), .val_o(sec0_v), .co_o(sec0_co)
   );
   bcd_digit_updown #(.W(SEC1_W), .MAX(SEC1_MAX)) u_sec1 (
      .clk(clk), .clr_i(clr), .load_i(load), .load_val_i(preset_sat.sec1),
      .en_i(sec0_co), .down_i(down), .val_o(sec1_v), .co_o(sec1_co)
   );
   bcd_digit_updown #(.W(MIN_W), .MAX(MAX_MIN)) u_min (
      .clk(clk), .clr_i(clr), .load_i(load), .load_val_i(preset_sat.min),
      .en_i(sec1_co), .down_i(down), .val_o(min_v), .co_o(min_co)
   );

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      done_d    = done_q;
      wrapped_d = 1'b0;
      presc_d   = presc_q;
      if (load) begin
         state_d = ST_STOP;
         done_d  = 1'b0;
         presc_d = '0;
      end else if (start_stop) begin
         presc_d = '0;
         done_d  = 1'b0;
         if (state_q == ST_RUN) begin
            state_d = ST_STOP;
         end else if (!((mode_e'(mode) == MODE_DOWN) && is_zero(live))) begin
            // Starting a down count from zero would underflow, so it stays stopped.
            state_d = ST_RUN;
            mode_d  = mode_e'(mode);
         end
      end else if (state_q == ST_RUN) begin
         presc_d   = tick ? '0 : presc_q + 1'b1;
         wrapped_d = adv && !down && min_co;
         if (adv && down && at_one) begin
            state_d = ST_STOP;
            done_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q   <= ST_STOP;
         mode_q    <= MODE_UP;
         done_q    <= 1'b0;
         wrapped_q <= 1'b0;
         presc_q   <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         done_q    <= done_d;
         wrapped_q <= wrapped_d;
         presc_q   <= presc_d;
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic  lap_held_q, lap_held_d;
   time_t hold_q, hold_d;

   always_comb begin
      lap_held_d = lap_held_q;
      hold_d     = hold_q;
      if (load) begin
         lap_held_d = 1'b0;
      end else if (lap) begin
         if ((state_q == ST_RUN) && !lap_held_q) begin
            lap_held_d = 1'b1;
            hold_d     = live;
         end else begin
            lap_held_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         lap_held_q <= 1'b0;
         hold_q     <= '0;
      end else begin
         lap_held_q <= lap_held_d;
         hold_q     <= hold_d;
      end
   end

   assign shown    = lap_held_q ? hold_q : live;
   assign lap_held = lap_held_q;
`else
   logic unused_lap;
   assign unused_lap = lap;
   assign shown      = live;
   assign lap_held   = 1'b0;
`endif

   assign min     = shown.min;
   assign sec1    = shown.sec1;
   assign sec0    = shown.sec0;
   assign deci    = shown.deci;
   assign running = (state_q == ST_RUN);
   assign wrapped = wrapped_q;
   assign done    = done_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: three instances (TICK_DIV/MAX_MIN = 1/9, 1/1, 4/2) share stimulus;
// a deci-second model tracks each of them.
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       clr, ss, mode, load, lap;
   logic [3:0] pm, p0, pd;
   logic [2:0] p1;

   logic [3:0] o_min  [3];
   logic [2:0] o_sec1 [3];
   logic [3:0] o_sec0 [3];
   logic [3:0] o_deci [3];
   logic       o_run  [3];
   logic       o_wrap [3];
   logic       o_done [3];
   logic       o_held [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      stopwatch_ctrl #(
         .TICK_DIV((g == 2) ? 4 : 1),
         .MAX_MIN ((g == 0) ? 9 : ((g == 1) ? 1 : 2))
      ) u_dut (
         .clk(clk), .clr(clr), .start_stop(ss), .mode(mode), .load(load),
         .preset_min(pm), .preset_sec1(p1), .preset_sec0(p0), .preset_deci(pd), .lap(lap),
         .min(o_min[g]), .sec1(o_sec1[g]), .sec0(o_sec0[g]), .deci(o_deci[g]),
         .running(o_run[g]), .wrapped(o_wrap[g]), .done(o_done[g]), .lap_held(o_held[g])
      );
   end

   typedef struct packed {
      logic [3:0] min;
      logic [2:0] sec1;
      logic [3:0] sec0;
      logic [3:0] deci;
      logic       running;
      logic       wrapped;
      logic       done;
      logic       lap_held;
   } obs_t;

   // Time held as a plain count of tenths of a second.
   typedef struct packed {
      int t;
      bit run;
      bit mode;
      bit done;
      bit wrap;
      int presc;
      bit held;
      int hold;
   } mdl_t;

   typedef struct packed {
      bit clr; bit ss; bit md; bit ld;
      int pm; int p1; int p0; int pd;
      int em; int e1; int e0; int ed;
      bit er; bit edn;
   } vec_t;

   mdl_t m [3];
   int   n_chk  = 0;
   int   n_fail = 0;

   function automatic int td_of(int k);
      return (k == 2) ? 4 : 1;
   endfunction

   function automatic int mm_of(int k);
      return (k == 0) ? 9 : ((k == 1) ? 1 : 2);
   endfunction

   function automatic int sat(int v, int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic mdl_t mstep(mdl_t s, int td, int mm);
      mdl_t n;
      int   period;
      bit   tk;
      n      = s;
      period = (mm + 1) * 600;
      tk     = s.run && (s.presc == td - 1);
      n.wrap = 1'b0;
      if (clr) begin
         n = '0;
         return n;
      end
      if (load) begin
         n.t = sat(int'(pm), mm) * 600 + sat(int'(p1), 5) * 100
             + sat(int'(p0), 9) * 10 + sat(int'(pd), 9);
         n.run = 1'b0; n.done = 1'b0; n.presc = 0; n.held = 1'b0;
         return n;
      end
      if (ss) begin
         n.presc = 0;
         n.done  = 1'b0;
         if (s.run) n.run = 1'b0;
         else if (!(mode && s.t == 0)) begin
            n.run  = 1'b1;
            n.mode = mode;
         end
      end else if (s.run) begin
         if (tk) begin
            n.presc = 0;
            if (!s.mode) begin
               n.t    = (s.t + 1) % period;
               n.wrap = (n.t == 0);
            end else begin
               n.t = s.t - 1;
               if (n.t == 0) begin
                  n.done = 1'b1;
                  n.run  = 1'b0;
               end
            end
         end else begin
            n.presc = s.presc + 1;
         end
      end
      if (LAP_EN && lap) begin
         if (s.run && !s.held) begin
            n.held = 1'b1;
            n.hold = s.t;
         end else begin
            n.held = 1'b0;
         end
      end
      return n;
   endfunction

   function automatic obs_t mk(int mi, int s1, int s0, int dc, bit r, bit w, bit dn, bit h);
      obs_t o;
      o.min = 4'(mi); o.sec1 = 3'(s1); o.sec0 = 4'(s0); o.deci = 4'(dc);
      o.running = r; o.wrapped = w; o.done = dn; o.lap_held = h;
      return o;
   endfunction

   function automatic obs_t mobs(mdl_t s);
      int d;
      d = s.held ? s.hold : s.t;
      return mk(d / 600, (d % 600) / 100, (d % 100) / 10, d % 10, s.run, s.wrap, s.done, s.held);
   endfunction

   function automatic obs_t dut_obs(int k);
      obs_t o;
      o.min = o_min[k]; o.sec1 = o_sec1[k]; o.sec0 = o_sec0[k]; o.deci = o_deci[k];
      o.running = o_run[k]; o.wrapped = o_wrap[k]; o.done = o_done[k]; o.lap_held = o_held[k];
      return o;
   endfunction

   function automatic string fmt(obs_t o);
      return $sformatf("%0d:%0d%0d.%0d run=%0d wrap=%0d done=%0d held=%0d", o.min, o.sec1,
                       o.sec0, o.deci, o.running, o.wrapped, o.done, o.lap_held);
   endfunction

   task automatic chk(string nm, obs_t act, obs_t exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %s, expected %s", nm, fmt(act), fmt(exp));
      end
   endtask

   task automatic chk_int(string nm, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick_clk();
      @(posedge clk);
      for (int k = 0; k < 3; k++) m[k] = mstep(m[k], td_of(k), mm_of(k));
      #1;
   endtask

   task automatic idle();
      clr = 1'b0; ss = 1'b0; load = 1'b0; lap = 1'b0;
   endtask

   task automatic load_preset(int a, int b, int c, int d);
      pm = 4'(a); p1 = 3'(b); p0 = 4'(c); pd = 4'(d);
      load = 1'b1;
      tick_clk();
      load = 1'b0;
   endtask

   vec_t tbl [20];
   int   wraps, wrap_at;

   initial begin
      tbl[0]  = '{1,0,0,0, 0,0,0,0,    0,0,0,0, 0,0};
      tbl[1]  = '{0,0,0,1, 12,7,12,15, 9,5,9,9, 0,0};
      tbl[2]  = '{0,0,0,1, 3,2,4,5,    3,2,4,5, 0,0};
      tbl[3]  = '{0,1,0,0, 0,0,0,0,    3,2,4,5, 1,0};
      tbl[4]  = '{0,0,0,0, 0,0,0,0,    3,2,4,6, 1,0};
      tbl[5]  = '{0,0,1,0, 0,0,0,0,    3,2,4,7, 1,0};
      tbl[6]  = '{0,1,0,0, 0,0,0,0,    3,2,4,7, 0,0};
      tbl[7]  = '{0,0,0,0, 0,0,0,0,    3,2,4,7, 0,0};
      tbl[8]  = '{0,0,0,1, 0,0,0,1,    0,0,0,1, 0,0};
      tbl[9]  = '{0,1,1,0, 0,0,0,0,    0,0,0,1, 1,0};
      tbl[10] = '{0,0,0,0, 0,0,0,0,    0,0,0,0, 0,1};
      tbl[11] = '{0,0,0,0, 0,0,0,0,    0,0,0,0, 0,1};
      tbl[12] = '{0,1,1,0, 0,0,0,0,    0,0,0,0, 0,0};
      tbl[13] = '{0,1,0,0, 0,0,0,0,    0,0,0,0, 1,0};
      tbl[14] = '{0,0,0,0, 0,0,0,0,    0,0,0,1, 1,0};
      tbl[15] = '{1,1,0,0, 0,0,0,0,    0,0,0,0, 0,0};
      tbl[16] = '{0,0,0,0, 0,0,0,0,    0,0,0,0, 0,0};
      tbl[17] = '{0,1,0,1, 0,5,9,9,    0,5,9,9, 0,0};
      tbl[18] = '{0,1,0,0, 0,0,0,0,    0,5,9,9, 1,0};
      tbl[19] = '{0,0,0,0, 0,0,0,0,    1,0,0,0, 1,0};

      idle();
      mode = 1'b0; pm = '0; p1 = '0; p0 = '0; pd = '0;
      for (int k = 0; k < 3; k++) m[k] = '0;

      clr = 1'b1;
      tick_clk();
      tick_clk();
      clr = 1'b0;
      for (int k = 0; k < 3; k++) chk($sformatf("reset_%0d", k), dut_obs(k), mk(0,0,0,0,0,0,0,0));

      for (int i = 0; i < 20; i++) begin
         clr = tbl[i].clr; ss = tbl[i].ss; mode = tbl[i].md; load = tbl[i].ld;
         pm = 4'(tbl[i].pm); p1 = 3'(tbl[i].p1); p0 = 4'(tbl[i].p0); pd = 4'(tbl[i].pd);
         tick_clk();
         idle();
         chk($sformatf("vec%0d", i), dut_obs(0),
             mk(tbl[i].em, tbl[i].e1, tbl[i].e0, tbl[i].ed, tbl[i].er, 1'b0, tbl[i].edn, 1'b0));
      end

      // Up count to one minute on the 1/9 unit and a full wrap on the 1/1 unit.
      clr = 1'b1; tick_clk(); clr = 1'b0;
      mode = 1'b0; ss = 1'b1; tick_clk(); ss = 1'b0;
      wraps = 0; wrap_at = -1;
      for (int i = 1; i <= 1200; i++) begin
         tick_clk();
         if (o_wrap[1]) begin
            wraps++;
            wrap_at = i;
         end
         if (i == 600) chk("up_600", dut_obs(0), mk(1,0,0,0,1,0,0,0));
      end
      chk_int("wrap_count", wraps, 1);
      chk_int("wrap_tick", wrap_at, 1200);
      chk("wrap_zero", dut_obs(1), mk(0,0,0,0,1,1,0,0));
      tick_clk();
      chk("wrap_cont", dut_obs(1), mk(0,0,0,1,1,0,0,0));

      // Down count from 0:01.5 to done, then a start_stop at zero.
      load_preset(0, 0, 1, 5);
      mode = 1'b1; ss = 1'b1; tick_clk(); ss = 1'b0;
      for (int i = 0; i < 15; i++) tick_clk();
      chk("down_done", dut_obs(0), mk(0,0,0,0,0,0,1,0));
      for (int i = 0; i < 20; i++) begin
         tick_clk();
         chk("down_hold", dut_obs(0), mk(0,0,0,0,0,0,1,0));
      end
      ss = 1'b1; tick_clk(); ss = 1'b0;
      chk("down_restart", dut_obs(0), mk(0,0,0,0,0,0,0,0));

      // Prescaler timing on the TICK_DIV=4 unit.
      clr = 1'b1; tick_clk(); clr = 1'b0;
      mode = 1'b0; ss = 1'b1; tick_clk(); ss = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         tick_clk();
         chk_int($sformatf("presc_wait_%0d", e), int'(o_deci[2]), 0);
      end
      tick_clk();
      chk("presc_first", dut_obs(2), mk(0,0,0,1,1,0,0,0));
      for (int e = 0; e < 3; e++) tick_clk();
      ss = 1'b1; tick_clk(); ss = 1'b0;
      chk("stop_on_tick", dut_obs(2), mk(0,0,0,1,0,0,0,0));

      // Saturating preset on each limit, then clr mid-count.
      load_preset(12, 7, 12, 15);
      chk("sat_9", dut_obs(0), mk(9,5,9,9,0,0,0,0));
      chk("sat_1", dut_obs(1), mk(1,5,9,9,0,0,0,0));
      chk("sat_2", dut_obs(2), mk(2,5,9,9,0,0,0,0));
      mode = 1'b0; ss = 1'b1; tick_clk(); ss = 1'b0;
      tick_clk();
      chk("wrap_max9", dut_obs(0), mk(0,0,0,0,1,1,0,0));
      tick_clk(); tick_clk();
      clr = 1'b1; tick_clk(); clr = 1'b0;
      chk("clr_run", dut_obs(0), mk(0,0,0,0,0,0,0,0));
      tick_clk();
      chk("clr_stays", dut_obs(0), mk(0,0,0,0,0,0,0,0));

`ifdef STOPWATCH_LAP_EN
      mode = 1'b0; ss = 1'b1; tick_clk(); ss = 1'b0;
      for (int i = 0; i < 32; i++) tick_clk();
      chk("lap_pre", dut_obs(0), mk(0,0,3,2,1,0,0,0));
      lap = 1'b1; tick_clk(); lap = 1'b0;
      chk("lap_hold", dut_obs(0), mk(0,0,3,2,1,0,0,1));
      for (int i = 0; i < 18; i++) begin
         tick_clk();
         chk("lap_frozen", dut_obs(0), mk(0,0,3,2,1,0,0,1));
      end
      lap = 1'b1; tick_clk(); lap = 1'b0;
      chk("lap_release", dut_obs(0), mk(0,0,5,2,1,0,0,0));
`endif

      // Random traffic against the model on all three units.
      clr = 1'b1; tick_clk(); clr = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         clr  = ($urandom_range(0, 99) == 0);
         load = ($urandom_range(0, 29) == 0);
         ss   = ($urandom_range(0, 11) == 0);
         lap  = ($urandom_range(0, 9) == 0);
         mode = 1'($urandom_range(0, 1));
         pm   = 4'($urandom_range(0, 15));
         p1   = 3'($urandom_range(0, 7));
         p0   = 4'($urandom_range(0, 15));
         pd   = 4'($urandom_range(0, 15));
         tick_clk();
         for (int k = 0; k < 3; k++) chk($sformatf("rand_u%0d_c%0d", k, i), dut_obs(k), mobs(m[k]));
      end
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Parametrised successor to the single-mode stopwatch. It counts in min:sec1 sec0.deci format and adds:
- start/stop control
- count-up and count-down modes
- preset load
- configurable tick prescaler and minute limit
- wrap and done flags
- optional lap-hold display

It sits between the board clock and the 7-segment display driver.

Parameters:
- TICK_DIV, 1, clk cycles per 0.1 s tick (1 means clk is already 10 Hz); legal range 1..2^20
- MAX_MIN, 9, highest minute value (0..9); minute digit wraps/borrows at this limit

Ports:
- clk  in  1  system clock, rising-edge
- clr  in  1  reset; synchronous, active-high (already decided)
- start_stop  in  1  one-cycle pulse; toggles run state
- mode  in  1  0 = count up, 1 = count down; sampled only while stopped
- load  in  1  one-cycle pulse; loads preset digits and stops
- preset_min  in  4  preset minute, 0..MAX_MIN
- preset_sec1  in  3  preset tens of seconds, 0..5
- preset_sec0  in  4  preset seconds, 0..9
- preset_deci  in  4  preset tenths, 0..9
- lap  in  1  one-cycle pulse; lap-hold toggle (macro only)
- min  out  4  displayed minutes
- sec1  out  3  displayed tens of seconds
- sec0  out  4  displayed seconds
- deci  out  4  displayed tenths
- running  out  1  high while counting
- wrapped  out  1  one-cycle pulse on up-mode rollover
- done  out  1  sticky; down-mode reached 0:00.0
- lap_held  out  1  high while display is frozen

Behaviour:
- Reset (clr=1 at an edge):
  - all digits 0; running, wrapped, done, lap_held all 0
  - prescaler 0; latched mode = 0 (up)
  - clr dominates every other input.
- Priority below clr: load > start_stop > tick.
- Prescaler:
  - counts 0..TICK_DIV-1 only while running
  - tick is true when running and prescaler == TICK_DIV-1
  - prescaler clears on start, stop and load.
  - First digit change occurs exactly TICK_DIV edges after running rises.
- Outputs are registered. Digits change on the same edge that tick is true. No combinational input-to-output paths.
- Up mode, on each tick:
  - deci increments 0..9; at 9 it goes to 0 and carries into sec0.
  - sec0 0..9 carries into sec1; sec1 0..5 carries into min; min 0..MAX_MIN.
  - At MAX_MIN:59.9 the next tick gives 0:00.0, wrapped=1 for that cycle, and counting continues.
- Down mode, on each tick:
  - symmetric borrow chain: deci 0 goes to 9 and borrows, and so on.
  - On the tick that reaches 0:00.0: running=0 and done=1.
  - done clears on clr, load or start_stop.
  - start_stop while stopped at 0:00.0 in down mode: running stays 0 and done clears (no underflow).
- Mode latching:
  - mode is latched on the start edge (running 0->1).
  - mode changes while running are ignored.
- start_stop:
  - toggles running on the next edge.
  - Simultaneous start_stop and tick: the stop takes effect and the tick increment is discarded.
- load:
  - Digits take preset values; running=0, done=0, prescaler=0.
  - Out-of-range presets saturate to their max (min at MAX_MIN, sec1 at 5, sec0/deci at 9).
- Mid-operation clr: everything returns to reset values on that edge, and counting does not resume until a new start_stop.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined:
  - A lap pulse while running and lap_held=0 copies the live digits into hold registers and sets lap_held=1. Outputs then show the held digits while the live count continues.
  - A second lap pulse clears lap_held, and outputs show live digits on the next edge.
  - lap while stopped: clears lap_held only.
  - clr and load clear lap_held.
  - wrapped and done still follow the live count.
- Not defined: lap is ignored, lap_held is tied 0, outputs are always live, and no hold registers exist.

Decomposition:
- Package stopwatch_pkg holds:
  - digit width constants (MIN_W=4, SEC1_W=3, SEC0_W=4, DECI_W=4)
  - digit limits (DECI_MAX=9, SEC0_MAX=9, SEC1_MAX=5)
  - a mode enum (MODE_UP=0, MODE_DOWN=1)
  - a packed time_t struct {min, sec1, sec0, deci}.
- One sub-module, bcd_digit_updown: a single digit with parametrised max, inc/dec enable, and carry/borrow out. It is instantiated four times in a chain.

Test Plan:
- TICK_DIV=1: clr, start_stop, run 600 cycles -> reads 1:00.0, running=1, wrapped=0.
- TICK_DIV=1, MAX_MIN=1: start from reset, run 1200 ticks -> 0:00.0 with wrapped=1 for exactly one cycle on the 1200th tick; count continues to 0:00.1.
- Load 0:01.5, mode=1, start_stop -> after 15 ticks reads 0:00.0, done=1, running=0; 20 further cycles unchanged; start_stop -> done=0, running=0.
- TICK_DIV=4: start at cycle 0 -> deci=1 at the 4th edge after running rises; start_stop on the tick edge -> running=0 and deci unchanged.
- Load presets 12,7,12,15 with MAX_MIN=9 -> display 9:59.9; clr during a running count -> 0:00.0, running=0 next edge.
- STOPWATCH_LAP_EN defined: at 0:03.2 pulse lap -> display holds 0:03.2 for 20 ticks, lap_held=1; second lap -> display 0:05.2 next edge, lap_held=0.
